// File: rtl/similarity_filter_pipe.sv
// similarity_filter_pipe: 3-stage 3x3 similarity filter (sort, bounds, noisy decision) with ready/valid and noisy counter
// Build option: SIM_MEDIAN_REPLACE_EN defined -> noisy pixels replaced by the median, otherwise by 0.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en                  detection enable, captured with each accepted window
//   win_valid/win_ready input handshake; window slot k = window[k*DW +: DW], slot 4 = centre
//   th_a, th_b          similarity thresholds, captured with each accepted window
//   cnt_clr             synchronous clear of noisy_count (wins over increment)
//   res_valid/res_ready output handshake
//   pixel, decision     filtered pixel and noisy flag
//   max_ij, min_ij      saturated bounds s[5]+th_a and s[3]-th_a
//   noisy_count         saturating count of delivered noisy results
module similarity_filter_pipe #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [9*DW-1:0]   window,
    input  logic [DW-1:0]     th_a,
    input  logic [DW-1:0]     th_b,
    input  logic              cnt_clr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     pixel,
    output logic              decision,
    output logic [DW-1:0]     max_ij,
    output logic [DW-1:0]     min_ij,
    output logic [CNT_W-1:0]  noisy_count
);
    logic                  advance, v1, v2, en1, en2, noisy;
    logic [8:0][DW-1:0]    w1, s2, srt;
    logic [DW-1:0]         ta1, tb1, ta2, tb2, c2, tmp;
    logic [DW:0]           sa, sb;
    logic [DW-1:0]         mx, mn, hi, lo, nmax, nmin, rep;

    // whole pipeline moves as one; it only stalls when a result is waiting
    assign advance   = !res_valid | res_ready;
    assign win_ready = advance;

    always_comb begin
        srt = w1;
        tmp = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (srt[j] > srt[j+1]) begin
                    tmp      = srt[j];
                    srt[j]   = srt[j+1];
                    srt[j+1] = tmp;
                end
    end

    always_comb begin
        sa    = {1'b0, s2[5]} + {1'b0, ta2};
        sb    = {1'b0, s2[4]} + {1'b0, tb2};
        mx    = sa[DW] ? '1 : sa[DW-1:0];
        hi    = sb[DW] ? '1 : sb[DW-1:0];
        mn    = s2[3] > ta2 ? s2[3] - ta2 : '0;
        lo    = s2[4] > tb2 ? s2[4] - tb2 : '0;
        nmax  = mx < hi ? mx : hi;
        nmin  = mn > lo ? mn : lo;
        noisy = en2 & ((c2 >= nmax) | (c2 <= nmin));
`ifdef SIM_MEDIAN_REPLACE_EN
        rep   = s2[4];
`else
        rep   = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; en1 <= 1'b0; w1 <= '0; ta1 <= '0; tb1 <= '0;
            v2 <= 1'b0; en2 <= 1'b0; s2 <= '0; c2 <= '0; ta2 <= '0; tb2 <= '0;
            res_valid <= 1'b0; pixel <= '0; decision <= 1'b0; max_ij <= '0; min_ij <= '0;
        end else if (advance) begin
            v1        <= win_valid;
            en1       <= en;
            w1        <= window;
            ta1       <= th_a;
            tb1       <= th_b;
            v2        <= v1;
            en2       <= en1;
            s2        <= srt;
            c2        <= w1[4];
            ta2       <= ta1;
            tb2       <= tb1;
            res_valid <= v2;
            pixel     <= noisy ? rep : c2;
            decision  <= noisy;
            max_ij    <= mx;
            min_ij    <= mn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            noisy_count <= '0;
        else if (cnt_clr)
            noisy_count <= '0;
        else if (res_valid & res_ready & decision & ~&noisy_count)
            noisy_count <= noisy_count + 1'b1;
    end
endmodule

// File: tb/tb_similarity_filter_pipe.sv
// tb_similarity_filter_pipe: randomized and directed checks of similarity_filter_pipe against a reference model
module tb_similarity_filter_pipe;
    logic        clk = 0, rst_n = 0, en = 1, win_valid = 0, res_ready = 1, cnt_clr = 0;
    logic [71:0] window = '0;
    logic [7:0]  th_a = 15, th_b = 60;
    logic        win_ready, res_valid, decision;
    logic [7:0]  pixel, max_ij, min_ij;
    logic [15:0] noisy_count;

    typedef struct {
        logic [7:0] pix;
        logic       dec;
        logic [7:0] mx;
        logic [7:0] mn;
    } res_t;

    res_t q[$];
    int   checks = 0, passed = 0, cnt_m = 0, n;
    logic acc;

    similarity_filter_pipe #(.DW(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .win_valid(win_valid), .win_ready(win_ready),
        .window(window), .th_a(th_a), .th_b(th_b), .cnt_clr(cnt_clr),
        .res_valid(res_valid), .res_ready(res_ready), .pixel(pixel), .decision(decision),
        .max_ij(max_ij), .min_ij(min_ij), .noisy_count(noisy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // r-th smallest value of the nine slots
    function automatic int ostat(input logic [71:0] w, input int r);
        for (int v = 0; v < 256; v++) begin
            int c = 0;
            for (int k = 0; k < 9; k++) if (int'(w[k*8 +: 8]) <= v) c++;
            if (c > r) return v;
        end
        return 255;
    endfunction

    function automatic res_t model(input logic [71:0] w, input logic e, input int a, input int b);
        res_t r;
        int s3 = ostat(w, 3), s4 = ostat(w, 4), s5 = ostat(w, 5), c = int'(w[39:32]);
        int mx = (s5 + a > 255) ? 255 : s5 + a;
        int mn = (s3 - a < 0) ? 0 : s3 - a;
        int hi = (s4 + b > 255) ? 255 : s4 + b;
        int lo = (s4 - b < 0) ? 0 : s4 - b;
        int nmax = mx < hi ? mx : hi;
        int nmin = mn > lo ? mn : lo;
        bit nz = e && (c >= nmax || c <= nmin);
`ifdef SIM_MEDIAN_REPLACE_EN
        r.pix = nz ? 8'(s4) : 8'(c);
`else
        r.pix = nz ? 8'd0 : 8'(c);
`endif
        r.dec = nz;
        r.mx  = 8'(mx);
        r.mn  = 8'(mn);
        return r;
    endfunction

    function automatic logic [71:0] mk(input int c, input int o);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(k == 4 ? c : o);
        return w;
    endfunction

    function automatic logic [71:0] rnd_win();
        logic [71:0] w;
        int base = $urandom_range(0, 255);
        for (int k = 0; k < 9; k++) begin
            int v = base + int'($urandom_range(0, 30)) - 15;
            w[k*8 +: 8] = 8'(v < 0 ? 0 : (v > 255 ? 255 : v));
        end
        case ($urandom_range(0, 3))
            0: w[39:32] = 8'd255;
            1: w[39:32] = 8'd0;
            default: ;
        endcase
        return w;
    endfunction

    // one clock cycle: drive, check visible result against model, advance clock, check counter
    task automatic step(input logic v, input logic [71:0] w, input logic e, input logic rr,
                        input logic clr, output logic a);
        logic del, d;
        win_valid = v; window = w; en = e; res_ready = rr; cnt_clr = clr;
        #1;
        chk("win_ready", win_ready, !res_valid | res_ready);
        a   = win_valid & win_ready;
        del = res_valid & res_ready;
        d   = 1'b0;
        if (res_valid) begin
            if (q.size() == 0) chk("unexpected_result", res_valid, 0);
            else begin
                chk("pixel", pixel, q[0].pix);
                chk("decision", decision, q[0].dec);
                chk("max_ij", max_ij, q[0].mx);
                chk("min_ij", min_ij, q[0].mn);
                d = q[0].dec;
                if (del) void'(q.pop_front());
            end
        end
        if (a) q.push_back(model(w, e, th_a, th_b));
        @(posedge clk);
        if (clr) cnt_m = 0;
        else if (del && d && cnt_m < 65535) cnt_m++;
        #1;
        chk("noisy_count", noisy_count, cnt_m);
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 20) begin
            step(0, '0, 1, 1, 0, acc);
            b++;
        end
        chk("drained", q.size(), 0);
    endtask

    // accept one window, then count edges until its result is visible
    task automatic lat(input logic [71:0] w, input logic e, output int cyc);
        step(1, w, e, 1, 0, acc);
        cyc = 1;
        while (!res_valid && cyc < 10) begin
            step(0, '0, 1, 1, 0, acc);
            cyc++;
        end
    endtask

    initial begin
        #2;
        chk("rst_valid", res_valid, 0);
        chk("rst_ready", win_ready, 1);
        chk("rst_pixel", pixel, 0);
        chk("rst_count", noisy_count, 0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        lat(mk(100, 100), 1, n);
        chk("latency", n, 3);
        chk("t1_max", max_ij, 115);
        chk("t1_min", min_ij, 85);
        chk("t1_dec", decision, 0);
        chk("t1_pix", pixel, 100);
        drain();

        lat(mk(255, 100), 1, n);
        chk("t2_dec", decision, 1);
`ifdef SIM_MEDIAN_REPLACE_EN
        chk("t2_pix", pixel, 100);
`else
        chk("t2_pix", pixel, 0);
`endif
        drain();
        chk("t2_count", noisy_count, 1);

        lat(mk(255, 250), 1, n);
        chk("t3_max_sat", max_ij, 255);
        chk("t3_dec_hi", decision, 1);
        drain();
        lat(mk(0, 5), 1, n);
        chk("t3_min_sat", min_ij, 0);
        chk("t3_dec_lo", decision, 1);
        drain();

        // six windows with a five-cycle downstream stall in the middle
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            step(1, rnd_win(), 1, !(c >= 3 && c < 8), 0, acc);
            if (acc) n++;
            if (c == 6) chk("t4_full_ready", win_ready, 0);
        end
        chk("t4_sent", n, 6);
        drain();

        // bypass window, then clear coinciding with a noisy delivery
        lat(mk(255, 100), 0, n);
        chk("t5_pix", pixel, 255);
        chk("t5_dec", decision, 0);
        drain();
        lat(mk(255, 100), 1, n);
        step(0, '0, 1, 1, 1, acc);
        chk("t5_clr", noisy_count, 0);

        // random traffic with changing thresholds and enable
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                th_a = 8'($urandom_range(0, 80));
                th_b = 8'($urandom_range(0, 160));
            end
            step($urandom_range(0, 3) != 0, rnd_win(), $urandom_range(0, 5) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, acc);
        end
        drain();
        th_a = 15; th_b = 60;

        // asynchronous reset with two windows in flight
        step(1, rnd_win(), 1, 1, 0, acc);
        step(1, rnd_win(), 1, 1, 0, acc);
        #2 rst_n = 0;
        #1;
        chk("r6_valid", res_valid, 0);
        chk("r6_pixel", pixel, 0);
        chk("r6_max", max_ij, 0);
        chk("r6_ready", win_ready, 1);
        chk("r6_count", noisy_count, 0);
        q.delete();
        cnt_m = 0;
        win_valid = 0;
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;
        chk("r6_idle", res_valid, 0);
        lat(mk(100, 100), 1, n);
        chk("r6_latency", n, 3);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
